// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: access-size encodings, FSM states,
// and the helper that turns a size code into a byte count.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational load formatter: moves the addressed bytes to the LSBs and
// sign- or zero-extends them to the full word width.
module dmem_load_extend
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = 3
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted_s;
  logic              sign_s;
  int                nbits_s;

  // Lane select, then fill every bit above the access width with the extension bit.
  always_comb begin
    data      = '0;
    shifted_s = word >> {offset, 3'b000};
    nbits_s   = int'(size_bytes(size)) * 8;
    case (size)
      SZ_B:    sign_s = shifted_s[7];
      SZ_H:    sign_s = shifted_s[15];
      SZ_W:    sign_s = shifted_s[31];
      default: sign_s = shifted_s[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits_s) begin
        data[i] = shifted_s[i];
      end else begin
        data[i] = sign_s & ~is_unsigned;
      end
    end
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with hardware clear after reset.
// Optional macro DMEM_DEBUG_TAPS_EN exposes the whole array on dbg_words.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_DEBUG_TAPS_EN
  ,
  output logic [DEPTH_BYTES*8-1:0] dbg_words
`endif
);

  localparam int BPW   = DATA_W / 8;
  localparam int WORDS = DEPTH_BYTES / BPW;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

  logic [DATA_W-1:0] mem_r [WORDS];
  state_e            state_r, state_nxt_s;
  logic [IDX_W-1:0]  cnt_r;

  logic              accept_s, err_s, store_we_s, clear_we_s;
  logic [3:0]        sz_bytes_s;
  logic [ADDR_W:0]   end_s;
  logic [IDX_W-1:0]  idx_s;
  logic [OFF_W-1:0]  off_s;
  logic [BPW-1:0]    byte_en_s;
  logic [DATA_W-1:0] wdata_sh_s, ext_s;

  assign ready      = (state_r == RUN);
  assign clear_we_s = (state_r == CLEAR) && !reset;

  // Clear walks every word once, then the memory serves requests forever.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == IDX_W'(WORDS - 1)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= CLEAR;
    else       state_r <= state_nxt_s;
  end

  // Clear word pointer.
  always_ff @(posedge clk) begin
    if (reset)                   cnt_r <= '0;
    else if (state_r == CLEAR)   cnt_r <= cnt_r + IDX_W'(1);
  end

  // Request decode: errors, word index, byte lanes and lane-aligned store data.
  always_comb begin
    accept_s   = req_valid && ready && !reset;
    sz_bytes_s = size_bytes(req_size);
    end_s      = {1'b0, req_addr} + {{(ADDR_W - 3){1'b0}}, sz_bytes_s};
    err_s      = ((req_addr[3:0] & (sz_bytes_s - 4'd1)) != 4'd0)
               || (end_s > DEPTH_L)
               || (sz_bytes_s > 4'(BPW));
    idx_s      = req_addr[OFF_W +: IDX_W];
    off_s      = req_addr[OFF_W-1:0];
    wdata_sh_s = req_wdata << {off_s, 3'b000};
    byte_en_s  = '0;
    for (int b = 0; b < BPW; b++) begin
      byte_en_s[b] = (b >= int'(off_s)) && (b < int'(off_s) + int'(sz_bytes_s));
    end
    store_we_s = accept_s && req_write && !err_s;
  end

  // Array write port: clear has priority, stores use per-byte enables.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[cnt_r] <= '0;
    end else if (store_we_s) begin
      for (int b = 0; b < BPW; b++) begin
        if (byte_en_s[b]) mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
      end
    end
  end

  dmem_load_extend #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_ext (
    .word        (mem_r[idx_s]),
    .offset      (off_s),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data        (ext_s)
  );

  // Response register; data and error hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_s;
      rsp_rdata <= (err_s || req_write) ? '0 : ext_s;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef DMEM_DEBUG_TAPS_EN
  for (genvar w = 0; w < WORDS; w++) begin : g_dbg
    assign dbg_words[w*DATA_W +: DATA_W] = mem_r[w];
  end
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: a 64-bit instance for the main
// scenarios and a 32-bit instance for the narrow-word checks.
module tb_data_memory_sized;

  logic clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  logic        reset_s;
  logic        v64_s, w64_s, u64_s, rdy64_s, rv64_s, re64_s;
  logic [1:0]  sz64_s;
  logic [63:0] a64_s, wd64_s, rd64_s;
  logic        v32_s, w32_s, u32_s, rdy32_s, rv32_s, re32_s;
  logic [1:0]  sz32_s;
  logic [63:0] a32_s;
  logic [31:0] wd32_s, rd32_s;
`ifdef DMEM_DEBUG_TAPS_EN
  logic [511:0] dbg64_s, dbg32_s;
`endif

  int errors = 0;
  int checks = 0;

  data_memory_sized #(.DATA_W(64), .DEPTH_BYTES(64), .ADDR_W(64)) dut64 (
    .clk(clk_s), .reset(reset_s), .req_valid(v64_s), .req_write(w64_s),
    .req_size(sz64_s), .req_unsigned(u64_s), .req_addr(a64_s),
    .req_wdata(wd64_s), .ready(rdy64_s), .rsp_valid(rv64_s),
    .rsp_rdata(rd64_s), .rsp_err(re64_s)
`ifdef DMEM_DEBUG_TAPS_EN
    , .dbg_words(dbg64_s)
`endif
  );

  data_memory_sized #(.DATA_W(32), .DEPTH_BYTES(64), .ADDR_W(64)) dut32 (
    .clk(clk_s), .reset(reset_s), .req_valid(v32_s), .req_write(w32_s),
    .req_size(sz32_s), .req_unsigned(u32_s), .req_addr(a32_s),
    .req_wdata(wd32_s), .ready(rdy32_s), .rsp_valid(rv32_s),
    .rsp_rdata(rd32_s), .rsp_err(re32_s)
`ifdef DMEM_DEBUG_TAPS_EN
    , .dbg_words(dbg32_s)
`endif
  );

  // One accepted request on the 64-bit instance; called and returning #1 after an edge.
  task automatic req64(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] d,
                       output logic v, output logic [63:0] rd, output logic e);
    v64_s = 1'b1; w64_s = w; sz64_s = sz; u64_s = u; a64_s = a; wd64_s = d;
    @(posedge clk_s); #1;
    v64_s = 1'b0;
    v = rv64_s; rd = rd64_s; e = re64_s;
  endtask

  task automatic req32(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [31:0] d,
                       output logic v, output logic [31:0] rd, output logic e);
    v32_s = 1'b1; w32_s = w; sz32_s = sz; u32_s = u; a32_s = a; wd32_s = d;
    @(posedge clk_s); #1;
    v32_s = 1'b0;
    v = rv32_s; rd = rd32_s; e = re32_s;
  endtask

  task automatic test_reset();
    logic v, e;
    logic [63:0] rd;
    int cnt;
    reset_s = 1'b1;
    @(posedge clk_s); @(posedge clk_s); #1;
    reset_s = 1'b0;
    checks++;
    if ({rdy64_s, rv64_s, re64_s} !== 3'b000 || rd64_s !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/rv/err=%b%b%b rdata=%h, required 000 and 0",
               rdy64_s, rv64_s, re64_s, rd64_s);
    end
    cnt = 0;
    while (rdy64_s !== 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk_s); #1;
    end
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL clear_length: ready low for %0d cycles, required 8", cnt);
    end
    for (int i = 0; i < 8; i++) begin
      req64(1'b0, 2'd3, 1'b1, 64'(i * 8), 64'd0, v, rd, e);
      checks++;
      if ({v, e} !== 2'b10 || rd !== 64'd0) begin
        errors++;
        $display("FAIL cleared_word%0d: v/err=%b%b rdata=%h, required 10 and 0", i, v, e, rd);
      end
    end
  endtask

  task automatic test_byte_ext();
    logic v, e;
    logic [63:0] rd;
    req64(1'b1, 2'd0, 1'b0, 64'd3, 64'h85, v, rd, e);
    checks++;
    if ({v, e} !== 2'b10 || rd !== 64'd0) begin
      errors++;
      $display("FAIL store_byte_rsp: v/err=%b%b rdata=%h, required 10 and 0", v, e, rd);
    end
    req64(1'b0, 2'd0, 1'b0, 64'd3, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FF85 || e !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_signed: got %h err=%b, required ffffffffffffff85 err=0", rd, e);
    end
    req64(1'b0, 2'd0, 1'b1, 64'd3, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'h85) begin
      errors++;
      $display("FAIL load_byte_unsigned: got %h, required 85", rd);
    end
    req64(1'b0, 2'd0, 1'b1, 64'd2, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'd0) begin
      errors++;
      $display("FAIL neighbour_addr2: got %h, required 0", rd);
    end
    req64(1'b0, 2'd0, 1'b1, 64'd4, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'd0) begin
      errors++;
      $display("FAIL neighbour_addr4: got %h, required 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    v64_s = 1'b1; w64_s = 1'b1; sz64_s = 2'd3; u64_s = 1'b0;
    a64_s = 64'd8; wd64_s = 64'h1122_3344_5566_7788;
    @(posedge clk_s); #1;
    checks++;
    if ({rv64_s, re64_s} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_store_rsp: v/err=%b%b, required 10", rv64_s, re64_s);
    end
    w64_s = 1'b0; sz64_s = 2'd1; u64_s = 1'b1; a64_s = 64'd10;
    @(posedge clk_s); #1;
    v64_s = 1'b0;
    checks++;
    if (rv64_s !== 1'b1 || rd64_s !== 64'h5566) begin
      errors++;
      $display("FAIL b2b_load: v=%b rdata=%h, required 1 and 5566", rv64_s, rd64_s);
    end
    @(posedge clk_s); #1;
    checks++;
    if (rv64_s !== 1'b0 || rd64_s !== 64'h5566) begin
      errors++;
      $display("FAIL rsp_pulse_hold: v=%b rdata=%h, required 0 and 5566", rv64_s, rd64_s);
    end
  endtask

  task automatic test_errors();
    logic v, e;
    logic [63:0] rd;
    req64(1'b0, 2'd2, 1'b1, 64'd6, 64'd0, v, rd, e);
    checks++;
    if ({v, e} !== 2'b11 || rd !== 64'd0) begin
      errors++;
      $display("FAIL misaligned_load: v/err=%b%b rdata=%h, required 11 and 0", v, e, rd);
    end
    req64(1'b1, 2'd3, 1'b0, 64'd64, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, e);
    checks++;
    if ({v, e} !== 2'b11 || rd !== 64'd0) begin
      errors++;
      $display("FAIL range_store: v/err=%b%b rdata=%h, required 11 and 0", v, e, rd);
    end
    req64(1'b1, 2'd3, 1'b0, 64'd12, 64'hFFFF_FFFF_FFFF_FFFF, v, rd, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store: err=%b, required 1", e);
    end
    req64(1'b0, 2'd0, 1'b1, 64'd63, 64'd0, v, rd, e);
    checks++;
    if ({v, e} !== 2'b10 || rd !== 64'd0) begin
      errors++;
      $display("FAIL last_byte: v/err=%b%b rdata=%h, required 10 and 0", v, e, rd);
    end
    req64(1'b0, 2'd3, 1'b1, 64'd0, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'h0000_0000_8500_0000 || e !== 1'b0) begin
      errors++;
      $display("FAIL word0_intact: got %h, required 0000000085000000", rd);
    end
    req64(1'b0, 2'd3, 1'b1, 64'd8, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'h1122_3344_5566_7788) begin
      errors++;
      $display("FAIL word1_intact: got %h, required 1122334455667788", rd);
    end
    req64(1'b0, 2'd3, 1'b1, 64'd56, 64'd0, v, rd, e);
    checks++;
    if (rd !== 64'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL word7_intact: got %h err=%b, required 0 err=0", rd, e);
    end
  endtask

  task automatic test_midclear_reset();
    logic v, e;
    logic [63:0] rd;
    logic seen;
    int cnt;
    seen = 1'b0;
    reset_s = 1'b1;
    @(posedge clk_s); #1;
    reset_s = 1'b0;
    v64_s = 1'b1; w64_s = 1'b0; sz64_s = 2'd0; u64_s = 1'b1; a64_s = 64'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_s); #1;
      if (rv64_s !== 1'b0) seen = 1'b1;
    end
    reset_s = 1'b1;
    @(posedge clk_s); #1;
    reset_s = 1'b0;
    cnt = 0;
    while (rdy64_s !== 1'b1 && cnt < 20) begin
      if (rv64_s !== 1'b0) seen = 1'b1;
      cnt++;
      if (cnt == 5) v64_s = 1'b0;
      @(posedge clk_s); #1;
    end
    v64_s = 1'b0;
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL midclear_length: ready low for %0d cycles, required 8", cnt);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_rsp: rsp_valid seen=%b during clear, required 0", seen);
    end
    req64(1'b0, 2'd0, 1'b1, 64'd3, 64'd0, v, rd, e);
    checks++;
    if ({v, e} !== 2'b10 || rd !== 64'd0) begin
      errors++;
      $display("FAIL recleared_byte: v/err=%b%b rdata=%h, required 10 and 0", v, e, rd);
    end
  endtask

  task automatic test_dut32();
    logic v, e;
    logic [31:0] rd;
    int cnt;
    cnt = 0;
    while (rdy32_s !== 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk_s); #1;
    end
    checks++;
    if (rdy32_s !== 1'b1) begin
      errors++;
      $display("FAIL w32_ready: ready=%b, required 1", rdy32_s);
    end
    req32(1'b0, 2'd3, 1'b1, 64'd0, 32'd0, v, rd, e);
    checks++;
    if ({v, e} !== 2'b11 || rd !== 32'd0) begin
      errors++;
      $display("FAIL w32_illegal_size: v/err=%b%b rdata=%h, required 11 and 0", v, e, rd);
    end
    req32(1'b1, 2'd2, 1'b0, 64'd4, 32'hDEAD_BEEF, v, rd, e);
    req32(1'b0, 2'd1, 1'b0, 64'd6, 32'd0, v, rd, e);
    checks++;
    if (rd !== 32'hFFFF_DEAD || e !== 1'b0) begin
      errors++;
      $display("FAIL w32_half_signed: got %h err=%b, required ffffdead err=0", rd, e);
    end
    req32(1'b0, 2'd2, 1'b1, 64'd4, 32'd0, v, rd, e);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL w32_word: got %h, required deadbeef", rd);
    end
  endtask

  initial begin
    reset_s = 1'b1;
    v64_s = 1'b0; w64_s = 1'b0; sz64_s = 2'd0; u64_s = 1'b0; a64_s = 64'd0; wd64_s = 64'd0;
    v32_s = 1'b0; w32_s = 1'b0; sz32_s = 2'd0; u32_s = 1'b0; a32_s = 64'd0; wd32_s = 32'd0;
    test_reset();
    test_byte_ext();
    test_back_to_back();
    test_errors();
    test_midclear_reset();
    test_dut32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Parametrised, byte-addressed, little-endian data memory for the pipelined core's MEM stage. It supports byte, half, word and double accesses, with sign or zero extension on loads, and returns read data one cycle after the request is accepted. Natural-alignment and range errors are reported instead of corrupting memory. After reset, a hardware clear sequence zeroes the array before any request is accepted.

Parameters:
DATA_W, 64, word width in bits; legal values 32 or 64.
DEPTH_BYTES, 64, memory size in bytes; must be a power of two and a multiple of DATA_W/8.
ADDR_W, 64, width of the request address.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, taken LSB-aligned.
ready  out  1  a request is accepted when req_valid && ready.
rsp_valid  out  1  one-cycle pulse: result of the request accepted in the previous cycle.
rsp_rdata  out  DATA_W  extended load data; 0 for stores and for errored requests.
rsp_err  out  1  previous accepted request was misaligned, out of range, or illegal size.

Behaviour:
- Storage: DEPTH_BYTES/(DATA_W/8) words of DATA_W bits, each with per-byte write enables.
- FSM states: CLEAR, RUN.
- Reset (any cycle, including mid-clear):
  - state <= CLEAR; clear counter <= 0.
  - ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Any request in flight is dropped with no response.
- CLEAR: writes word[counter] <= 0 and increments the counter once per cycle. After the last word is written, state <= RUN. Duration = DEPTH_BYTES/(DATA_W/8) cycles; ready stays 0 throughout.
- RUN: ready = 1. At most one request per cycle; there is no back-pressure after clear.
- Error checks, applied when a request is accepted:
  - misaligned: req_addr mod (1<<req_size) != 0.
  - out of range: req_addr + (1<<req_size) > DEPTH_BYTES.
  - illegal size: req_size == 3 with DATA_W == 32.
  - An errored request writes nothing. Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Store: bytes are written at the accepting clock edge using lane enables derived from addr[log2(DATA_W/8)-1:0] and size. Next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Load: the word is registered at the accepting edge. Next cycle:
  - selected bytes are shifted to the LSB, then sign- or zero-extended to DATA_W;
  - rsp_valid = 1 with that data on rsp_rdata.
- Load in cycle N+1 to an address stored in cycle N returns the new data; the write commits at edge N.
- rsp_rdata and rsp_err hold their last values while rsp_valid = 0.
- A request with req_valid = 1 while ready = 0 is ignored; no response is produced.

Optional Feature:
DMEM_DEBUG_TAPS_EN
- Defined: adds output dbg_words, width (DEPTH_BYTES*8), a flat, word-ordered, continuous view of the array for testbench sort checking; word 0 sits in the LSBs.
- Undefined: the port and its wiring are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - size encoding constants SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3;
  - the FSM state enum (CLEAR, RUN);
  - function size_bytes(size).
- Sub-module dmem_load_extend: combinational lane select plus extension (inputs word, byte offset, size, unsigned; output DATA_W).

Test Plan:
- Reset with DATA_W = 64, DEPTH_BYTES = 64 -> ready = 0 for exactly 8 cycles after reset deasserts, then 1; a load of addr 0..56 (double) returns 0.
- Store byte 0x85 at addr 3; load byte signed at addr 3 -> rsp_rdata = 0xFFFFFFFFFFFFFF85; same load unsigned -> 0x0000000000000085; addr 2 and addr 4 bytes unchanged.
- Store double 0x1122334455667788 at addr 8, then the next cycle load half unsigned at addr 10 -> 0x5566, rsp_valid exactly one cycle after acceptance.
- Load word at addr 6 -> rsp_err = 1, rsp_rdata = 0; store double at addr 64 -> rsp_err = 1 and no byte of memory changes.
- Assert reset at cycle 4 of clear after storing nothing -> ready stays 0 for a full 8 more cycles; a request driven during clear gets no rsp_valid.
- DATA_W = 32 build: req_size = 3 -> rsp_err = 1; store word 0xDEADBEEF at addr 4, load half signed at addr 6 -> 0xFFFFDEAD.
